fft_readout: RTL and testbench
==============================

Name: fft_readout

Overview:
- Consumer at the output end of the fft block.
- On the rising edge of fft `done`, captures the first N/2 complex bins from the fft `wd` stream and computes |X[k]|^2 for each. Only N/2 bins are needed because the input is real, so the spectrum is symmetric.
- Buffers the magnitudes, then streams them to the MCU/SPI side over a valid/ready handshake with first/last framing.
- Pulses `fft_restart` after the frame drains so the top level can reset and reload the fft.

Parameters:
- width, 16, bit width of each real/imag component of fft `wd`.
- N_2, 5, log2 of FFT points. Capture and buffer depth is 2**(N_2-1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- fft_done  input  1  fft `done` level. Stays high while the fft output index free-runs and wraps.
- fft_wd  input  2*width  fft complex output, combinational per cycle. [2*width-1:width] is signed real, [width-1:0] is signed imag.
- out_data  output  2*width  unsigned magnitude squared.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.
- out_first  output  1  marks bin 0; qualified by out_valid.
- out_last  output  1  marks bin N/2-1; qualified by out_valid.
- busy  output  1  high in any state other than IDLE.
- fft_restart  output  1  one-cycle pulse after the last beat is accepted.
- overrun  output  1  sticky; set when a frame is dropped.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including overrun, and out_data=0.
  - Counters and pipeline valids clear.
  - Reset has priority over every other event, mid-capture or mid-stream.
- Edge detect: done_q is registered fft_done. rise = fft_done & ~done_q.
- Cycle numbering: cycle 0 is the first cycle with fft_done high. In cycle c, fft_wd holds bin c.
- State IDLE:
  - On rise, capture bin 0 in that same cycle, set cap_idx=1 and go to CAPTURE.
- State CAPTURE:
  - Captures bin cap_idx each cycle, then increments cap_idx.
  - After capturing bin N/2-1 (cycle N/2-1), go to DRAIN.
  - If fft_done falls during CAPTURE (fft reset): abort to IDLE, discard the partial frame, set overrun, and do not pulse fft_restart.
- Magnitude pipeline:
  - Stage 1 registers re*re and im*im, each signed width x signed width.
  - Stage 2 registers the unsigned sum into buffer[k].
  - The sum fits in 2*width bits: the worst case (-2^(w-1))^2*2 = 2^(2w-1). No saturation is needed.
  - Bin k is written to the buffer at the end of cycle k+1.
- State DRAIN:
  - Lasts until the final buffer write (end of cycle N/2), then go to STREAM.
- State STREAM:
  - The buffer read is registered into out_data.
  - First out_valid is in cycle N/2+2; this is 18 for N_2=5.
  - A beat transfers when out_valid & out_ready. The next bin is presented the following cycle, so a sustained rate of 1 beat/cycle is supported.
  - While out_valid & ~out_ready: out_data, out_first and out_last hold stable.
  - out_first=1 on the bin 0 beat only. out_last=1 on the bin N/2-1 beat only.
  - After the last beat transfers: out_valid=0 next cycle, fft_restart=1 for exactly that one cycle, and state returns to IDLE.
- Overrun:
  - A rise seen while in DRAIN or STREAM drops the new frame and sets overrun.
  - The current frame completes normally.
  - overrun clears only on reset.
- fft_done held high through IDLE after a frame does not re-trigger; only a fresh rise starts a frame.

Test Plan:
- Basic frame, N_2=5: assert fft_done, drive bin k = {re=k, im=-k} with out_ready=1 -> 16 beats, data = 2k^2 (0,2,8,...,450), first valid in cycle 18, out_first on beat 0, out_last on beat 15, fft_restart pulses once the cycle after beat 15.
- Extremes: bin0 = {-32768,-32768} -> 0x8000_0000; bin1 = {3,-4} -> 25; bin2 = {32767,0} -> 0x3FFF_0001.
- Backpressure: out_ready toggles 1,0,0,1 per cycle across the stream -> no beat lost or duplicated, out_data stable while stalled, 16 transfers total, values match the basic frame.
- Overrun: drop then re-raise fft_done during STREAM -> current 16 beats delivered intact, overrun=1 and stays 1, no second frame output.
- Abort: fft_done falls at cycle 7 of CAPTURE -> return to IDLE, out_valid never asserts, overrun=1, no fft_restart. A later rise produces a correct full frame.
- Reset mid-stream: reset=0 after beat 5 -> next cycle out_valid=0, busy=0, overrun=0, fft_restart=0. A subsequent rise yields a clean 16-beat frame starting at bin 0.

Source files
------------

// File: rtl/fft_readout_if.sv
// Signal bundle between the fft output stage, the readout block and the MCU/SPI stream sink.
interface fft_readout_if #(
  parameter int width = 16
);
  logic               fft_done;
  logic [2*width-1:0] fft_wd;
  logic [2*width-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_first;
  logic               out_last;
  logic               busy;
  logic               fft_restart;
  logic               overrun;

  modport master (
    input  fft_done, fft_wd, out_ready,
    output out_data, out_valid, out_first, out_last, busy, fft_restart, overrun
  );

  modport slave (
    output fft_done, fft_wd, out_ready,
    input  out_data, out_valid, out_first, out_last, busy, fft_restart, overrun
  );
endinterface

// File: rtl/fft_readout.sv
// Captures the lower half of an fft frame, buffers |X[k]|^2 per bin and streams the
// magnitudes out with first/last framing, then requests an fft restart.
module fft_readout #(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input logic          clk,
  input logic          reset,
  fft_readout_if.master bus
);
  localparam int HALF = 2 ** (N_2 - 1);
  localparam int IW   = N_2 - 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, STREAM} state_t;

  state_t             state;
  logic               done_q;
  logic               rise;
  logic               capture;
  logic [IW-1:0]      cap_idx;
  logic [IW-1:0]      cap_sel;
  logic [N_2-1:0]     rd_idx;

  logic signed [width-1:0]   re_p0, im_p0;
  logic signed [2*width-1:0] re_sq_p1, im_sq_p1;
  logic [IW-1:0]             idx_p1;
  logic                      vld_p1;
  logic [2*width-1:0]        buffer [HALF];

  logic [2*width-1:0] out_data;
  logic               out_valid, out_first, out_last, fft_restart, overrun;

  function automatic logic signed [2*width-1:0] sq(input logic signed [width-1:0] a);
    logic signed [2*width-1:0] ax;
    ax = a;
    return ax * ax;
  endfunction

  // Sum of two squares peaks at 2^(2*width-1), so it always fits unsigned without saturation.
  function automatic logic [2*width-1:0] mag_sum(input logic signed [2*width-1:0] a,
                                                 input logic signed [2*width-1:0] b);
    return $unsigned(a) + $unsigned(b);
  endfunction

  assign rise    = bus.fft_done & ~done_q;
  assign re_p0   = bus.fft_wd[2*width-1:width];
  assign im_p0   = bus.fft_wd[width-1:0];
  assign capture = ((state == IDLE) && rise) || ((state == CAPTURE) && bus.fft_done);
  assign cap_sel = (state == CAPTURE) ? cap_idx : '0;

  // Stage 1: component squares
  always_ff @(posedge clk) begin
    if (capture) begin
      re_sq_p1 <= sq(re_p0);
      im_sq_p1 <= sq(im_p0);
      idx_p1   <= cap_sel;
    end
  end

  // Stage 2: magnitude into the bin buffer
  always_ff @(posedge clk) begin
    if (vld_p1) buffer[idx_p1] <= mag_sum(re_sq_p1, im_sq_p1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      cap_idx     <= '0;
      rd_idx      <= '0;
      vld_p1      <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      fft_restart <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      done_q      <= bus.fft_done;
      vld_p1      <= capture;
      fft_restart <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            cap_idx <= IW'(1);
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!bus.fft_done) begin
            overrun <= 1'b1;
            state   <= IDLE;
          end else begin
            cap_idx <= cap_idx + 1'b1;
            if (cap_idx == '1) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The last bin lands in the buffer at the end of this cycle.
          if (rise) overrun <= 1'b1;
          rd_idx <= '0;
          state  <= STREAM;
        end
        STREAM: begin
          if (rise) overrun <= 1'b1;
          if (!out_valid || bus.out_ready) begin
            if (out_valid && out_last) begin
              out_valid   <= 1'b0;
              out_first   <= 1'b0;
              out_last    <= 1'b0;
              fft_restart <= 1'b1;
              state       <= IDLE;
            end else if (!rd_idx[N_2-1]) begin
              out_data  <= buffer[rd_idx[IW-1:0]];
              out_valid <= 1'b1;
              out_first <= (rd_idx == '0);
              out_last  <= (rd_idx[IW-1:0] == '1);
              rd_idx    <= rd_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_data    = out_data;
  assign bus.out_valid   = out_valid;
  assign bus.out_first   = out_first;
  assign bus.out_last    = out_last;
  assign bus.fft_restart = fft_restart;
  assign bus.overrun     = overrun;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_fft_readout.sv
// Directed bench for fft_readout: drives fft frames, predicts each magnitude beat into a
// queue and checks the stream, framing, restart pulse and overrun behaviour.
module tb_fft_readout;
  localparam int W  = 16;
  localparam int NB = 16;

  typedef struct packed {
    logic [2*W-1:0] data;
    logic           first;
    logic           last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_readout_if #(.width(W)) bus ();
  fft_readout #(.width(W), .N_2(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;
  int beats = 0;
  int cyc   = 0;
  int widx  = 0;
  bit ready_mode = 1'b0;
  bit mon_en     = 1'b0;
  logic [2*W-1:0] tbl [32];
  beat_t sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] mag(input logic [2*W-1:0] w);
    logic signed [W-1:0] r, i;
    longint rr, ii, s;
    r  = w[2*W-1:W];
    i  = w[W-1:0];
    rr = r;
    ii = i;
    s  = rr * rr + ii * ii;
    return s[2*W-1:0];
  endfunction

  task automatic load_basic();
    for (int k = 0; k < 32; k++) begin
      logic signed [W-1:0] a, b;
      a = W'(k);
      b = W'(-k);
      tbl[k] = {a, b};
    end
  endtask

  task automatic push_frame();
    for (int k = 0; k < NB; k++) sb.push_back('{mag(tbl[k]), (k == 0), (k == NB - 1)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.fft_done) begin
      widx++;
      bus.fft_wd = tbl[widx % 32];
    end
    if (ready_mode) bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
  endtask

  task automatic raise();
    bus.fft_done = 1'b1;
    widx = 0;
    bus.fft_wd = tbl[0];
  endtask

  task automatic wait_frame(input int b0);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      tick();
      @(negedge clk);
      ok = (sb.size() == 0) && !bus.busy && !bus.out_valid;
    end
    check("frame_done", ok, 1);
    check("beat_count", beats - b0, NB);
  endtask

  task automatic pulse_reset();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard side: every accepted beat is popped and compared.
  bit prev_last = 1'b0;
  bit stalled   = 1'b0;
  logic [2*W+1:0] hold = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("fft_restart", bus.fft_restart, prev_last);
      if (prev_last) check("valid_after_last", bus.out_valid, 0);
      if (stalled && bus.out_valid) check("stall_hold", {bus.out_data, bus.out_first, bus.out_last}, hold);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) check("beat_expected", sb.size(), 1);
        else begin
          beat_t e;
          e = sb.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_first", bus.out_first, e.first);
          check("out_last", bus.out_last, e.last);
        end
        beats++;
      end
      prev_last = bus.out_valid && bus.out_ready && bus.out_last;
      stalled   = bus.out_valid && !bus.out_ready;
      hold      = {bus.out_data, bus.out_first, bus.out_last};
    end
  end

  initial begin
    int b0;
    bit seen;
    reset         = 1'b0;
    bus.fft_done  = 1'b0;
    bus.fft_wd    = '0;
    bus.out_ready = 1'b1;
    load_basic();
    tick();
    tick();
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_restart", bus.fft_restart, 0);
    check("rst_first_last", {bus.out_first, bus.out_last}, 0);
    mon_en = 1'b1;
    tick();
    reset = 1'b1;

    // Basic frame with latency checks.
    push_frame();
    b0 = beats;
    tick();
    raise();
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_capture", bus.busy, 1);
      if (c == 17) check("valid_c17", bus.out_valid, 0);
      if (c == 18) check("valid_c18", bus.out_valid, 1);
      if (c < 18) tick();
    end
    wait_frame(b0);
    check("overrun_basic", bus.overrun, 0);
    tick();
    bus.fft_done = 1'b0;

    // Extreme component values.
    for (int k = 3; k < 32; k++) tbl[k] = $urandom;
    tbl[0] = {16'h8000, 16'h8000};
    tbl[1] = {16'd3, 16'hfffc};
    tbl[2] = {16'h7fff, 16'h0000};
    push_frame();
    b0 = beats;
    tick();
    raise();
    wait_frame(b0);
    tick();
    bus.fft_done = 1'b0;

    // Backpressure 1,0,0,1.
    load_basic();
    push_frame();
    b0 = beats;
    ready_mode = 1'b1;
    tick();
    raise();
    wait_frame(b0);
    ready_mode = 1'b0;
    tick();
    bus.fft_done  = 1'b0;
    bus.out_ready = 1'b1;

    // Abort mid-capture.
    pulse_reset();
    check("overrun_cleared", bus.overrun, 0);
    b0 = beats;
    tick();
    raise();
    for (int c = 1; c <= 7; c++) tick();
    bus.fft_done = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      @(negedge clk);
    end
    check("abort_busy", bus.busy, 0);
    check("abort_overrun", bus.overrun, 1);
    check("abort_beats", beats - b0, 0);
    push_frame();
    b0 = beats;
    tick();
    raise();
    wait_frame(b0);
    tick();
    bus.fft_done = 1'b0;

    // Overrun: rise during STREAM.
    pulse_reset();
    check("overrun_cleared2", bus.overrun, 0);
    push_frame();
    b0 = beats;
    tick();
    raise();
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      @(negedge clk);
      seen = bus.out_valid;
    end
    check("stream_reached", seen, 1);
    tick();
    bus.fft_done = 1'b0;
    tick();
    raise();
    wait_frame(b0);
    check("overrun_set", bus.overrun, 1);
    b0 = beats;
    for (int n = 0; n < 40; n++) begin
      tick();
      @(negedge clk);
    end
    check("no_retrigger_busy", bus.busy, 0);
    check("no_second_frame", beats - b0, 0);
    check("overrun_sticky", bus.overrun, 1);
    tick();
    bus.fft_done = 1'b0;

    // Reset mid-stream after beat 5.
    push_frame();
    b0 = beats;
    tick();
    raise();
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      tick();
      @(negedge clk);
      seen = (beats - b0 == 6);
    end
    check("six_beats", seen, 1);
    tick();
    reset         = 1'b0;
    bus.out_ready = 1'b0;
    bus.fft_done  = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_overrun", bus.overrun, 0);
    check("mid_rst_restart", bus.fft_restart, 0);
    sb.delete();
    bus.out_ready = 1'b1;
    push_frame();
    b0 = beats;
    tick();
    raise();
    wait_frame(b0);
    tick();
    bus.fft_done = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
